// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Contents: data width, register count, register index width, and the
// requester IDs used to index the arbiter request/grant vectors.
package regfile_wb_arbiter_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned RIDX_W  = 5;
    localparam int unsigned NREQ    = 2;
    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
// Ports:
//   clk, reset : clock and async active-high reset
//   req        : request vector, index REQ_ALU / REQ_LSU
//   block      : forces both grants low (pipeline flush)
//   gnt        : combinational one-hot grant; a grant implies a transfer
module rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            block,
    output logic [NREQ-1:0] gnt
);

    // Holds the ID of the requester that transferred most recently.
    logic last_q;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt = '0;
        if (!reset && !block) begin
            if (req[REQ_ALU] && req[REQ_LSU]) begin
                if (last_q == 1'(REQ_LSU)) begin
                    gnt[REQ_ALU] = 1'b1;
                end else begin
                    gnt[REQ_LSU] = 1'b1;
                end
            end else begin
                gnt = req;
            end
        end
    end

    // Last grant moves only when a transfer actually happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'(REQ_LSU);
        end else if (|gnt) begin
            last_q <= gnt[REQ_LSU];
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and load unit into the register file,
// with a pending-write scoreboard.
// Ports:
//   clk, reset              : clock and async active-high reset
//   alu_valid/ready/rd/data : ALU writeback request (requester 0)
//   lsu_valid/ready/rd/data : load-unit writeback request (requester 1)
//   alloc_valid, alloc_rd   : issue stage marks a destination pending
//   flush                   : blocks grants and clears the scoreboard
//   rd, wEn, data           : registered register-file write port
//   busy                    : scoreboard, bit i = register i write outstanding
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN,
    parameter int unsigned NREG = regfile_wb_arbiter_pkg::NREG
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      alu_valid,
    output logic                                      alu_ready,
    input  logic [regfile_wb_arbiter_pkg::RIDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]                           alu_data,
    input  logic                                      lsu_valid,
    output logic                                      lsu_ready,
    input  logic [regfile_wb_arbiter_pkg::RIDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]                           lsu_data,
    input  logic                                      alloc_valid,
    input  logic [regfile_wb_arbiter_pkg::RIDX_W-1:0] alloc_rd,
    input  logic                                      flush,
    output logic [regfile_wb_arbiter_pkg::RIDX_W-1:0] rd,
    output logic                                      wEn,
    output logic [XLEN-1:0]                           data,
    output logic [NREG-1:0]                           busy
);

    import regfile_wb_arbiter_pkg::*;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic              xfer;
    logic [RIDX_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   busy_next;

    always_comb begin
        req          = '0;
        req[REQ_ALU] = alu_valid;
        req[REQ_LSU] = lsu_valid;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .block (flush),
        .gnt   (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign lsu_ready = gnt[REQ_LSU];

    // Mux the granted request onto the write path.
    always_comb begin
        xfer     = |gnt;
        sel_rd   = alu_rd;
        sel_data = alu_data;
        if (gnt[REQ_LSU]) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
    end

    // Write-port stage; x0 transfers are accepted but leave rd/data untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wEn  <= 1'b0;
            rd   <= '0;
            data <= '0;
        end else begin
            wEn <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                rd   <= sel_rd;
                data <= sel_data;
            end
        end
    end

    // Scoreboard: alloc set overrides a same-cycle write clear; flush wins over both.
    always_comb begin
        busy_next = busy;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (wEn && (rd == RIDX_W'(i))) begin
                busy_next[i] = 1'b0;
            end
            if (alloc_valid && (alloc_rd == RIDX_W'(i))) begin
                busy_next[i] = 1'b1;
            end
        end
        if (flush) begin
            busy_next = '0;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed scenarios then random
// traffic checked against a behavioural model of the arbitration and
// scoreboard rules.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [RIDX_W-1:0] alu_rd, lsu_rd, alloc_rd, rd;
    logic [XLEN-1:0]   alu_data, lsu_data, data;
    logic              alloc_valid, flush, wEn;
    logic [NREG-1:0]   busy;

    regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .flush       (flush),
        .rd          (rd),
        .wEn         (wEn),
        .data        (data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t               exp_q[$];
    int unsigned       errors = 0;
    int unsigned       checks = 0;
    bit                mon_en = 1'b0;
    // Model state: expected write port, scoreboard and last winner.
    bit                m_wen;
    logic [RIDX_W-1:0] m_rd;
    logic [XLEN-1:0]   m_data;
    logic [NREG-1:0]   m_busy;
    int unsigned       m_last;
    bit                g_alu, g_lsu;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wen  = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_busy = '0;
        m_last = REQ_LSU;
        g_alu  = 1'b0;
        g_lsu  = 1'b0;
        exp_q.delete();
    endtask

    // Applies the rules to the inputs present this cycle (called at negedge).
    task automatic model_eval();
        logic [NREG-1:0]   nb;
        logic [RIDX_W-1:0] trd;
        logic [XLEN-1:0]   tdata;
        g_alu = 1'b0;
        g_lsu = 1'b0;
        if (!flush) begin
            if (alu_valid && lsu_valid) begin
                if (m_last == REQ_LSU) g_alu = 1'b1;
                else                   g_lsu = 1'b1;
            end else begin
                g_alu = alu_valid;
                g_lsu = lsu_valid;
            end
        end
        chk("alu_ready", 64'(alu_ready), 64'(g_alu));
        chk("lsu_ready", 64'(lsu_ready), 64'(g_lsu));
        nb = m_busy;
        if (m_wen) nb[m_rd] = 1'b0;
        if (alloc_valid && alloc_rd != '0) nb[alloc_rd] = 1'b1;
        if (flush) nb = '0;
        m_busy = nb;
        m_wen  = 1'b0;
        if (g_alu || g_lsu) begin
            m_last = g_alu ? REQ_ALU : REQ_LSU;
            trd    = g_alu ? alu_rd : lsu_rd;
            tdata  = g_alu ? alu_data : lsu_data;
            if (trd != '0) begin
                exp_q.push_back('{rd: trd, data: tdata});
                m_wen  = 1'b1;
                m_rd   = trd;
                m_data = tdata;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        alloc_valid = 1'b0;
        flush       = 1'b0;
    endtask

    function automatic logic [RIDX_W-1:0] rnd_rd();
        return ($urandom_range(0, 5) == 0) ? '0 : RIDX_W'($urandom_range(1, 15));
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                chk("wEn", 64'(wEn), 64'(m_wen));
                if (wEn) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no write", rd, data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_rd", 64'(rd), 64'(e.rd));
                        chk("wb_data", 64'(data), 64'(e.data));
                    end
                end else if (exp_q.size() != 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_missing: got no write expected rd=%0d", exp_q[0].rd);
                    exp_q.delete();
                end
                chk("rd_hold", 64'(rd), 64'(m_rd));
                chk("data_hold", 64'(data), 64'(m_data));
                chk("busy", 64'(busy), 64'(m_busy));
            end
        end
    end

    initial begin
        logic [NREG-1:0] bsnap;
        reset    = 1'b1;
        idle();
        alu_rd   = '0; alu_data = '0;
        lsu_rd   = '0; lsu_data = '0;
        alloc_rd = '0;
        model_reset();
        alu_valid = 1'b1;
        #1;
        chk("rst_wen", 64'(wEn), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(alu_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        idle();
        mon_en = 1'b1;

        // Both requesters continuously valid: ALU first, then alternate.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd2;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'd4;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_wen", 64'(wEn), 64'd1);
            chk("rr_rd", 64'(rd), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_data", 64'(data), (k % 2 == 0) ? 64'd2 : 64'd4);
        end
        idle();
        step();

        // Single ALU write, one-cycle latency, single-cycle wEn.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'd8;
        step();
        chk("single_wen", 64'(wEn), 64'd1);
        chk("single_rd", 64'(rd), 64'd3);
        chk("single_data", 64'(data), 64'd8);
        idle();
        step();
        chk("single_wen_drop", 64'(wEn), 64'd0);

        // Alloc then LSU write clears busy the cycle after wEn.
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        step();
        idle();
        chk("alloc5_set", 64'(busy[5]), 64'd1);
        step();
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'd32;
        step();
        idle();
        chk("busy5_during_wen", 64'(busy[5]), 64'd1);
        step();
        chk("busy5_cleared", 64'(busy[5]), 64'd0);

        // Write to x0: accepted, no wEn, scoreboard untouched.
        bsnap = busy;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'd16;
        step();
        idle();
        chk("x0_wen", 64'(wEn), 64'd0);
        chk("x0_busy", 64'(busy), 64'(bsnap));

        // Alloc of the same index on the cycle its write is on the port.
        alloc_valid = 1'b1; alloc_rd = 5'd4;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'd7;
        step();
        idle();
        alloc_valid = 1'b1; alloc_rd = 5'd4;
        step();
        idle();
        chk("alloc_wins", 64'(busy[4]), 64'd1);

        // Flush blocks a pending LSU request and clears the scoreboard.
        alloc_valid = 1'b1; alloc_rd = 5'd6;
        step();
        idle();
        chk("alloc6_set", 64'(busy[6]), 64'd1);
        flush = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA5;
        step();
        chk("flush_busy", 64'(busy), 64'd0);
        flush = 1'b0;
        step();
        idle();
        step();

        // Random traffic; ungranted requests are held stable.
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !g_alu)) begin
                alu_valid = ($urandom_range(0, 99) < 55);
                alu_rd    = rnd_rd();
                alu_data  = $urandom();
            end
            if (!(lsu_valid && !g_lsu)) begin
                lsu_valid = ($urandom_range(0, 99) < 55);
                lsu_rd    = rnd_rd();
                lsu_data  = $urandom();
            end
            alloc_valid = ($urandom_range(0, 99) < 40);
            alloc_rd    = rnd_rd();
            flush       = ($urandom_range(0, 99) < 5);
            step();
        end

        // Reset asserted while a transfer is about to register.
        idle();
        alloc_valid = 1'b1; alloc_rd = 5'd9;
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
        @(negedge clk);
        model_eval();
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midrst_wen", 64'(wEn), 64'd0);
        chk("midrst_rd", 64'(rd), 64'd0);
        chk("midrst_data", 64'(data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(alu_ready), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_no_write", 64'(wEn), 64'd0);
        reset  = 1'b0;
        idle();
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
